nubus_cpu_wbuf: RTL
===================

// Module: nubus_cpu_wbuf
// PURPOSE
// Posted-write buffer between the CPU bus and the cpu_* port of the NuBus master (nubus).
// CPU writes are acked as soon as they enter a FIFO; the FIFO drains to the master in order.
// Reads and locked accesses wait until the FIFO is empty, so ordering is strict.
// Read data and the read ack are returned to the CPU unchanged.
// PARAMETERS
// DEPTH      4   FIFO entries; power of 2, 2..16
// CNT_W      3   width of wbuf_count, $clog2(DEPTH)+1
// PORTS
// nub_clkn     in   1   clock; all flops on rising edge
// nub_resetn   in   1   asynchronous active-low reset
// cpu_valid    in   1   CPU request valid; held until cpu_ready
// cpu_addr     in   32  CPU byte address
// cpu_wdata    in   32  CPU write data
// cpu_write    in   4   byte strobes; 4'b0000 = read
// cpu_lock     in   1   locked access; bypasses buffering
// cpu_ready    out  1   one-cycle ack to CPU
// cpu_rdata    out  32  read data, valid while cpu_ready on a read
// mst_valid    out  1   request to NuBus master
// mst_addr     out  32  request address
// mst_wdata    out  32  request write data
// mst_write    out  4   request strobes
// mst_lock     out  1   request lock
// mst_ready    in   1   master ack (= ~nub_ackn)
// mst_rdata    in   32  master read data
// wbuf_count   out  CNT_W  entries in the FIFO (debug)
// BEHAVIOUR
// Reset: cpu_ready=0, cpu_rdata=0, mst_valid=0, mst_addr/wdata=0, mst_write=0,
//   mst_lock=0, wbuf_count=0; FIFO pointers cleared.
// FIFO: entry {addr,wdata,strb}; wr/rd pointers CNT_W bits wide; wrap modulo DEPTH;
//   full when count==DEPTH; empty when count==0.
// Posted write (cpu_valid, cpu_write!=0, cpu_lock=0, no CPU ack pending):
//   - not full: push at the edge, cpu_ready=1 for the next cycle only.
//   - full: stall with cpu_ready=0 and retry each cycle.
//   - push and pop in the same cycle: count unchanged. A push is allowed at full
//     only if a pop happens in the same cycle.
// After cpu_ready=1, the CPU must drop cpu_valid; the held request is ignored for that cycle.
// Master side FSM, states IDLE, WR, GAP, RD, LK:
//   IDLE: FIFO not empty -> WR, loading the head onto mst_*.
//     FIFO empty and a pending read -> RD; pending lock -> LK.
//   WR: mst_valid=1 until mst_ready is sampled 1; then pop, go to GAP.
//   GAP: mst_valid=0 for exactly one cycle, then IDLE. Back-to-back master
//     transactions are always separated by this idle cycle.
//   RD: forward cpu_addr, mst_write=0. On mst_ready: cpu_rdata<=mst_rdata,
//     cpu_ready=1 for one cycle, go to GAP.
//   LK: forward the CPU request with mst_lock=1, reads or writes, no buffering.
//     On mst_ready: cpu_ready=1, latch rdata on a read, go to GAP.
// A read or lock request arriving while the FIFO is non-empty waits with cpu_ready=0
//   until the FIFO drains (read-after-write ordering). No read forwarding from the FIFO.
// mst_* outputs are registered and stay stable while mst_valid=1.
// mst_ready while not in WR, RD or LK is ignored.
// Latency, empty FIFO: write ack 1 cycle after cpu_valid. Read ack 1 cycle after mst_ready.
// Reset mid-transfer: queued posted writes are discarded and mst_valid drops immediately.
// TESTING
// 1 Single write 0xF0000000/0x87654321/1111 -> cpu_ready after 1 clk; master sees the same
//   values; a read returns 0x87654321.
// 2 Write 5 words with DEPTH=4 and the master stalled -> acks for the first 4, the 5th stalls;
//   the 5th is accepted on the first pop; wbuf_count peaks at 4.
// 3 Write 0xF0000004 then an immediate read of it -> the read is issued only after the
//   write's mst_ready; data matches the written strobes (half 0 -> 0x00004321).
// 4 Lock read with 2 queued writes -> both writes drain first, then mst_lock=1 with the read;
//   there is one mst_valid=0 gap cycle between every transaction.
// 5 Assert nub_resetn=0 with 3 entries queued and WR active -> all outputs reach their reset
//   values asynchronously; no further master requests after release.
// 6 Wrap-around: 10 writes with a 1-wait master -> order is preserved across the pointer wrap;
//   byte strobes 0001/0010/0100/1000 are forwarded intact.

Source files
------------

// File: rtl/nubus_cpu_wbuf.sv
// ---------------------------------------------------------------------------
// NubusCpuWbuf : posted-write buffer between the CPU bus and the cpu_* port of
// the NuBus master.
//
// CPU writes are acknowledged as soon as they are queued in a small FIFO. The
// FIFO drains to the master strictly in order. Reads and locked accesses are
// held off until the FIFO is empty, so the master always sees CPU requests in
// program order. Read data and the read ack are passed back to the CPU.
//
// Ports
//   nub_clkn, nub_resetn          clock (rising edge) / async active-low reset
//   cpu_valid/addr/wdata/write/lock   CPU request (write==0 means read)
//   cpu_ready, cpu_rdata          one-cycle ack and read data back to the CPU
//   mst_valid/addr/wdata/write/lock   registered request to the NuBus master
//   mst_ready, mst_rdata          master ack and read data
//   wbuf_count                    number of queued posted writes (debug)
// ---------------------------------------------------------------------------
module nubus_cpu_wbuf #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             nub_clkn,
    input  logic             nub_resetn,
    input  logic             cpu_valid,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic [3:0]       cpu_write,
    input  logic             cpu_lock,
    output logic             cpu_ready,
    output logic [31:0]      cpu_rdata,
    output logic             mst_valid,
    output logic [31:0]      mst_addr,
    output logic [31:0]      mst_wdata,
    output logic [3:0]       mst_write,
    output logic             mst_lock,
    input  logic             mst_ready,
    input  logic [31:0]      mst_rdata,
    output logic [CNT_W-1:0] wbuf_count
);

    localparam int AW = CNT_W - 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        WR,
        GAP,
        RD,
        LK
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]  rdPtr_q, rdPtr_d;
    logic              mstValid_q, mstValid_d;
    logic [31:0]       mstAddr_q, mstAddr_d;
    logic [31:0]       mstWdata_q, mstWdata_d;
    logic [3:0]        mstWrite_q, mstWrite_d;
    logic              mstLock_q, mstLock_d;
    logic              cpuReady_q, cpuReady_d;
    logic [31:0]       cpuRdata_q, cpuRdata_d;

    // Each entry is {addr, wdata, strobes}.
    logic [67:0]       fifoMem [DEPTH];
    logic [67:0]       headEntry;
    logic [CNT_W-1:0]  count;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              reqActive;
    logic              isWrite;
    logic              push;
    logic              pop;

    // Pointers are one bit wider than the index, so their difference is the
    // occupancy and full/empty are unambiguous. While cpu_ready is high the
    // CPU is still holding the request it just got acked for, so that request
    // must not be acted on again.
    assign count     = wrPtr_q - rdPtr_q;
    assign fifoFull  = (count == FULL_CNT);
    assign fifoEmpty = (count == '0);
    assign reqActive = cpu_valid && !cpuReady_q;
    assign isWrite   = |cpu_write;
    assign pop       = (state_q == WR) && mst_ready;
    assign push      = reqActive && isWrite && !cpu_lock && (!fifoFull || pop);
    assign headEntry = fifoMem[rdPtr_q[AW-1:0]];

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge nub_clkn) begin
        if (push) begin
            fifoMem[wrPtr_q[AW-1:0]] <= {cpu_addr, cpu_wdata, cpu_write};
        end
    end

    // Next-state logic for the master-side FSM, the FIFO pointers and the
    // registered outputs. A write push always acks the CPU on the next cycle;
    // reads and locked accesses ack when the master completes them.
    always_comb begin
        state_d    = state_q;
        wrPtr_d    = push ? (wrPtr_q + ONE_CNT) : wrPtr_q;
        rdPtr_d    = pop  ? (rdPtr_q + ONE_CNT) : rdPtr_q;
        mstValid_d = mstValid_q;
        mstAddr_d  = mstAddr_q;
        mstWdata_d = mstWdata_q;
        mstWrite_d = mstWrite_q;
        mstLock_d  = mstLock_q;
        cpuReady_d = push;
        cpuRdata_d = cpuRdata_q;

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    state_d    = WR;
                    mstValid_d = 1'b1;
                    mstAddr_d  = headEntry[67:36];
                    mstWdata_d = headEntry[35:4];
                    mstWrite_d = headEntry[3:0];
                    mstLock_d  = 1'b0;
                end else if (reqActive && cpu_lock) begin
                    state_d    = LK;
                    mstValid_d = 1'b1;
                    mstAddr_d  = cpu_addr;
                    mstWdata_d = cpu_wdata;
                    mstWrite_d = cpu_write;
                    mstLock_d  = 1'b1;
                end else if (reqActive && !isWrite) begin
                    state_d    = RD;
                    mstValid_d = 1'b1;
                    mstAddr_d  = cpu_addr;
                    mstWdata_d = cpu_wdata;
                    mstWrite_d = 4'b0000;
                    mstLock_d  = 1'b0;
                end
            end
            WR: begin
                if (mst_ready) begin
                    state_d    = GAP;
                    mstValid_d = 1'b0;
                end
            end
            RD: begin
                if (mst_ready) begin
                    state_d    = GAP;
                    mstValid_d = 1'b0;
                    cpuReady_d = 1'b1;
                    cpuRdata_d = mst_rdata;
                end
            end
            LK: begin
                if (mst_ready) begin
                    state_d    = GAP;
                    mstValid_d = 1'b0;
                    mstLock_d  = 1'b0;
                    cpuReady_d = 1'b1;
                    if (mstWrite_q == 4'b0000) begin
                        cpuRdata_d = mst_rdata;
                    end
                end
            end
            GAP: begin
                state_d    = IDLE;
                mstValid_d = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                mstValid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any queued writes and drops
    // the master request immediately.
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q    <= IDLE;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            mstValid_q <= 1'b0;
            mstAddr_q  <= '0;
            mstWdata_q <= '0;
            mstWrite_q <= '0;
            mstLock_q  <= 1'b0;
            cpuReady_q <= 1'b0;
            cpuRdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            mstValid_q <= mstValid_d;
            mstAddr_q  <= mstAddr_d;
            mstWdata_q <= mstWdata_d;
            mstWrite_q <= mstWrite_d;
            mstLock_q  <= mstLock_d;
            cpuReady_q <= cpuReady_d;
            cpuRdata_q <= cpuRdata_d;
        end
    end

    assign cpu_ready  = cpuReady_q;
    assign cpu_rdata  = cpuRdata_q;
    assign mst_valid  = mstValid_q;
    assign mst_addr   = mstAddr_q;
    assign mst_wdata  = mstWdata_q;
    assign mst_write  = mstWrite_q;
    assign mst_lock   = mstLock_q;
    assign wbuf_count = count;

endmodule
